// File: rtl/io_tx_serializer.sv
// Buffers 16-bit io_out words in a small FIFO and shifts each one out LSB-first
// on an asynchronous serial line: start bit, 16 data bits, stop bit.
module io_tx_serializer #(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [15:0]              io_out,
    input  logic                     io_valid,
    output logic                     tx,
    output logic                     busy,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [3:0]     bit_q, bit_d;
    logic [15:0]    shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
    logic           full_q, full_d;
    logic           ovf_q, ovf_d;
    logic           push_s;
    logic           pop_s;
    logic           baud_end_s;
    logic           fifo_nonempty_s;

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_full  = full_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

    // Next-state logic for the frame FSM, FIFO bookkeeping and registered outputs.
    always_comb begin
        state_d         = state_q;
        baud_d          = baud_q;
        bit_d           = bit_q;
        shift_d         = shift_q;
        pop_s           = 1'b0;
        baud_end_s      = (baud_q == BAUD_LAST);
        fifo_nonempty_s = (count_q != {CW{1'b0}});

        case (state_q)
            S_IDLE: begin
                if (fifo_nonempty_s) begin
                    pop_s   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = {BW{1'b0}};
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_end_s) begin
                    baud_d  = {BW{1'b0}};
                    bit_d   = 4'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d  = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                if (baud_end_s) begin
                    baud_d  = {BW{1'b0}};
                    shift_d = {1'b0, shift_q[15:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd15) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    baud_d  = baud_q + BW'(1);
                end
            end
            S_STOP: begin
                if (baud_end_s) begin
                    baud_d = {BW{1'b0}};
                    // A queued word starts immediately so frames run back-to-back.
                    if (fifo_nonempty_s) begin
                        pop_s   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        push_s = io_valid & ((count_q != DEPTH_C) | pop_s);
        ovf_d  = ovf_q | (io_valid & ~push_s);

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE) | (count_d != {CW{1'b0}});
        full_d = (count_d == DEPTH_C);
    end

    // State, pointer and output registers; reset aborts any frame in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            baud_q   <= {BW{1'b0}};
            bit_q    <= 4'd0;
            shift_q  <= 16'h0000;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; contents are qualified by the pointers, so no reset is needed.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= io_out;
        end
    end

endmodule

// File: tb/tb_io_tx_serializer.sv
// Scoreboard bench for io_tx_serializer: stimulus queues expected words, a
// serial-line monitor decodes each frame and compares it against the queue.
module tb_io_tx_serializer;

    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int FRAME = 18 * CPB;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] io_out = 16'h0000;
    logic        io_valid = 1'b0;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic [2:0]  fifo_count;
    logic        overflow;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [15:0] exp_q[$];
    int          st_q[$];

    io_tx_serializer #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clock      (clock),
        .reset      (reset),
        .io_out     (io_out),
        .io_valid   (io_valid),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: sample every cycle of a frame, check shape, then compare the word.
    initial begin
        logic [71:0] s;
        logic [15:0] w;
        logic [15:0] e;
        bit          aborted;
        bit          ok;
        forever begin
            @(negedge clock);
            if (!reset && tx === 1'b0) begin
                st_q.push_back(cyc);
                s = '0;
                s[0] = tx;
                aborted = 1'b0;
                for (int j = 1; j < FRAME; j++) begin
                    @(negedge clock);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    s[j] = tx;
                end
                if (!aborted) begin
                    ok = (s[3:0] == 4'h0) && (s[71:68] == 4'hF);
                    w = 16'h0000;
                    for (int b = 0; b < 16; b++) begin
                        if (s[4+4*b +: 4] != {4{s[4+4*b]}}) ok = 1'b0;
                        w[b] = s[4+4*b];
                    end
                    chk("frame_shape", {31'd0, ok}, 32'd1);
                    if (exp_q.size() == 0) begin
                        chk("frame_unexpected", {16'd0, w}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_word", {16'd0, w}, {16'd0, e});
                    end
                end
            end
        end
    end

    task automatic push(input logic [15:0] w, input bit expect_tx);
        io_out   = w;
        io_valid = 1'b1;
        if (expect_tx) exp_q.push_back(w);
        @(negedge clock);
        io_valid = 1'b0;
    endtask

    task automatic wait_start(input int n);
        int k = 0;
        while (st_q.size() < n && k < 200) begin
            @(negedge clock);
            k++;
        end
        chk("start_seen", {31'd0, (st_q.size() >= n)}, 32'd1);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk("drain_in_time", {31'd0, (k < budget)}, 32'd1);
    endtask

    initial begin
        int sz;
        int st;
        int n;
        logic [15:0] wv;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {29'd0, fifo_count}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_full", {31'd0, fifo_full}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Single word 0xA5C3: latency and busy duration
        push(16'hA5C3, 1'b1);
        chk("single_count1", {29'd0, fifo_count}, 32'd1);
        chk("single_tx_idle", {31'd0, tx}, 32'd1);
        chk("single_busy", {31'd0, busy}, 32'd1);
        @(negedge clock);
        chk("single_tx_start", {31'd0, tx}, 32'd0);
        chk("single_count0", {29'd0, fifo_count}, 32'd0);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clock);
        end
        chk("single_busy_len", n, 32'd72);
        chk("single_tx_after", {31'd0, tx}, 32'd1);
        drain(50);

        // Back-to-back frames
        sz = st_q.size();
        push(16'h0001, 1'b1);
        chk("b2b_count_a", {29'd0, fifo_count}, 32'd1);
        push(16'h8000, 1'b1);
        chk("b2b_count_b", {29'd0, fifo_count}, 32'd1);
        chk("b2b_tx_start", {31'd0, tx}, 32'd0);
        drain(400);
        chk("b2b_frames", st_q.size(), sz + 2);
        if (st_q.size() >= sz + 2) chk("b2b_gap", st_q[sz+1] - st_q[sz], FRAME);

        // Full FIFO with push coinciding with stop-bit end
        sz = st_q.size();
        push(16'hBEEF, 1'b1);
        wait_start(sz + 1);
        push(16'h1111, 1'b1);
        push(16'h2222, 1'b1);
        push(16'h3333, 1'b1);
        push(16'h4444, 1'b1);
        chk("sim_count_full", {29'd0, fifo_count}, 32'd4);
        chk("sim_full", {31'd0, fifo_full}, 32'd1);
        chk("sim_ovf_pre", {31'd0, overflow}, 32'd0);
        st = (st_q.size() > sz) ? st_q[sz] : cyc;
        n = 0;
        while (cyc < st + 71 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("sim_align", cyc, st + 71);
        push(16'h7777, 1'b1);
        chk("sim_count", {29'd0, fifo_count}, 32'd4);
        chk("sim_full_after", {31'd0, fifo_full}, 32'd1);
        chk("sim_ovf", {31'd0, overflow}, 32'd0);
        chk("sim_tx_next", {31'd0, tx}, 32'd0);
        drain(800);

        // Overflow: fifth word dropped while mid-frame
        sz = st_q.size();
        push(16'hCAFE, 1'b1);
        wait_start(sz + 1);
        push(16'h1111, 1'b1);
        push(16'h2222, 1'b1);
        push(16'h3333, 1'b1);
        push(16'h4444, 1'b1);
        push(16'h5555, 1'b0);
        chk("ovf_count", {29'd0, fifo_count}, 32'd4);
        chk("ovf_full", {31'd0, fifo_full}, 32'd1);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        drain(800);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("ovf_drained", {29'd0, fifo_count}, 32'd0);

        // Reset mid-frame
        push(16'h1234, 1'b1);
        push(16'h5678, 1'b1);
        repeat (20) @(negedge clock);
        chk("mid_count_pre", {29'd0, fifo_count}, 32'd1);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_tx", {31'd0, tx}, 32'd1);
        chk("mid_rst_count", {29'd0, fifo_count}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clock);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("mid_rst_idle", {31'd0, tx}, 32'd1);

        // Pointer wrap: ten words spaced one frame apart
        for (int i = 0; i < 10; i++) begin
            wv = {i[3:0], ~i[3:0], i[3:0] ^ 4'h5, 4'hA};
            push(wv, 1'b1);
            repeat (FRAME - 1) @(negedge clock);
        end
        drain(400);
        chk("wrap_ovf", {31'd0, overflow}, 32'd0);
        chk("wrap_all_sent", exp_q.size(), 32'd0);
        chk("wrap_count", {29'd0, fifo_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_tx_serializer.md
Name: io_tx_serializer

Overview:
- Downstream consumer of the processor's 16-bit io_out port.
- Each word the core writes is captured into a small FIFO, then shifted out LSB-first on a single-wire asynchronous serial line (start bit, 16 data bits, stop bit).
- Lets the core issue bursts of output writes without stalling on the slow external link.

Parameters:
- DEPTH, 4, FIFO depth in 16-bit words; power of 2, minimum 2.
- CLKS_PER_BIT, 8, clock cycles per serial bit period; minimum 2.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- io_out  input  16  output word driven by the processor.
- io_valid  input  1  one-cycle write strobe; io_out is captured when high.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_full  output  1  high when the FIFO holds DEPTH words.
- fifo_count  output  clog2(DEPTH)+1  number of words currently queued.
- overflow  output  1  sticky flag: a write was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous): tx=1, busy=0, fifo_full=0, fifo_count=0, overflow=0, state=IDLE. FIFO pointers, shift register, bit counter and baud counter all clear. Reset asserted mid-frame aborts the frame, and tx returns high immediately.
- All outputs are registered or decoded from registers only; no combinational path from io_valid.
- FIFO: circular buffer with read/write pointers that wrap modulo DEPTH.
  - Push when io_valid=1 and either fifo_count<DEPTH or a pop occurs in the same cycle.
  - Push with FIFO full and no same-cycle pop: word is dropped, FIFO unchanged, overflow←1.
  - overflow clears only on reset.
  - Simultaneous push and pop leaves fifo_count unchanged.
- FSM states are IDLE, START, DATA, STOP. The baud counter counts 0..CLKS_PER_BIT-1; a bit ends when the counter reaches CLKS_PER_BIT-1.
  - IDLE: tx=1. If fifo_count>0, pop the head into the 16-bit shift register, clear the baud counter, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles. Then shift right, increment the bit index, and after bit 15 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if fifo_count>0, pop and go straight to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- Frame length is exactly 18*CLKS_PER_BIT cycles.
- Latency: a push at edge k into an empty FIFO with the FSM in IDLE gives fifo_count=1 after edge k; the pop at edge k+1 drives tx low.
- busy = (state!=IDLE) or (fifo_count!=0).
- fifo_full = (fifo_count==DEPTH).
- tx is driven from a flop, so it is glitch-free.

Test Plan:
- Reset with io_valid=0 → tx=1, busy=0, fifo_count=0, overflow=0; assert reset mid-frame → tx=1 the same cycle, fifo_count=0.
- CLKS_PER_BIT=4, single push of 0xA5C3 → tx low 4 cycles, then bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles; busy falls after 72 cycles.
- Push 0x0001, 0x8000 on consecutive cycles → two frames back-to-back with no idle cycles between the stop bit and the next start bit; fifo_count sequence 1,1→0 over time as each frame starts.
- DEPTH=4: with the FSM mid-frame, push 5 words (0x1111..0x5555) → fifo_count=4, fifo_full=1, overflow=1, 0x5555 never transmitted; first four words transmitted in order.
- FIFO full and the stop bit ends in the same cycle as io_valid=1 (0x7777) → pop and push both occur, fifo_count stays 4, overflow unchanged (0), 0x7777 later transmitted.
- More than 2*DEPTH pushes spaced one frame apart → pointer wrap-around verified; all words emerge in order, overflow=0.
